fir_resp_checker: RTL and testbench



---
 rtl/fir_resp_checker.sv | 133 +++++++++++++
 tb/tb_fir_resp_checker.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_resp_checker.sv
// Receive-side checker for the FIR stimulus loop: compares the y stream against a
// programmable golden frame for FRAMES frames and reports error count and pass/fail.
module fir_resp_checker #(
  parameter int unsigned DW      = 24,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned FRAMES  = 4,
  parameter int unsigned ERRW    = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [DW-1:0]   cfg_data,
  input  logic            start,
  input  logic [DW-1:0]   y_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic            mismatch,
  output logic [AW-1:0]   first_err_idx,
  output logic [DW-1:0]   first_err_got
);

  localparam int unsigned SW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int unsigned FW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  typedef enum logic [1:0] {IDLE, SKIP, CHECK, FIN} state_t;

  state_t          state, state_d;
  logic [SW-1:0]   skip_cnt, skip_cnt_d;
  logic [AW-1:0]   idx, idx_d;
  logic [FW-1:0]   frame, frame_d;
  logic            cmp_fail;
  logic            last_cmp;
  logic [ERRW-1:0] err_inc;

  logic [DW-1:0]   gold [DEPTH];
  logic [DW-1:0]   gold_rd;

  assign err_inc = (err_count == '1) ? err_count : err_count + ERRW'(1);

  always_comb begin
    state_d    = state;
    skip_cnt_d = skip_cnt;
    idx_d      = idx;
    frame_d    = frame;
    cmp_fail   = 1'b0;
    last_cmp   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          skip_cnt_d = SW'(LATENCY);
          idx_d      = '0;
          frame_d    = '0;
          state_d    = (LATENCY == 0) ? CHECK : SKIP;
        end
      end
      SKIP: begin
        skip_cnt_d = skip_cnt - SW'(1);
        if (skip_cnt == SW'(1)) state_d = CHECK;
      end
      CHECK: begin
        cmp_fail = (y_in != gold_rd);
        last_cmp = (idx == AW'(DEPTH - 1)) && (frame == FW'(FRAMES - 1));
        if (idx == AW'(DEPTH - 1)) begin
          idx_d   = '0;
          frame_d = frame + FW'(1);
        end else begin
          idx_d = idx + AW'(1);
        end
        if (last_cmp) state_d = FIN;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Golden read is registered one edge ahead of each compare (block-RAM style),
  // addressed by the index of the next compare. A write on the start edge thus
  // reaches the first compare only when at least one skip edge intervenes.
  always_ff @(posedge clk) begin
    if (state == IDLE && cfg_we) gold[cfg_addr] <= cfg_data;
    gold_rd <= gold[idx_d];
  end

  // done/busy/pass are updated on the final compare edge so that done is
  // visible exactly during the single FIN cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      skip_cnt      <= '0;
      idx           <= '0;
      frame         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      mismatch      <= 1'b0;
      first_err_idx <= '0;
      first_err_got <= '0;
    end else begin
      state    <= state_d;
      skip_cnt <= skip_cnt_d;
      idx      <= idx_d;
      frame    <= frame_d;
      done     <= 1'b0;
      mismatch <= cmp_fail;
      if (state == IDLE && start) begin
        busy          <= 1'b1;
        pass          <= 1'b0;
        err_count     <= '0;
        first_err_idx <= '0;
        first_err_got <= '0;
      end
      if (cmp_fail) begin
        err_count <= err_inc;
        if (err_count == '0) begin
          first_err_idx <= idx;
          first_err_got <= y_in;
        end
      end
      if (last_cmp) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == '0) && !cmp_fail;
      end
    end
  end

endmodule

// File: tb/tb_fir_resp_checker.sv
// Self-checking bench for fir_resp_checker: default build, ERRW=4 build and
// LATENCY=0 build run side by side against a frame-level reference model.
module tb_fir_resp_checker;

  logic        clk = 1'b0;
  logic        reset_n, cfg_we, start;
  logic [3:0]  cfg_addr;
  logic [23:0] cfg_data, y_a, y_c;

  logic        busy_a, done_a, pass_a, mism_a;
  logic [15:0] err_a;
  logic [3:0]  fidx_a;
  logic [23:0] fgot_a;
  logic        busy_b, done_b, pass_b, mism_b;
  logic [3:0]  err_b;
  logic [3:0]  fidx_b;
  logic [23:0] fgot_b;
  logic        busy_c, done_c, pass_c, mism_c;
  logic [15:0] err_c;
  logic [3:0]  fidx_c;
  logic [23:0] fgot_c;

  int total = 0;
  int bad   = 0;

  logic [23:0] gold_m [16];
  logic [23:0] stim_a [64];
  logic [23:0] stim_c [64];
  bit          ov_en = 1'b0;
  logic [23:0] ov_val = '0;
  int ba, da, ma, bb, db, mb, bc, dc, mc;

  always #5 clk = ~clk;

  fir_resp_checker u_a (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .y_in(y_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .mismatch(mism_a), .first_err_idx(fidx_a), .first_err_got(fgot_a));

  fir_resp_checker #(.ERRW(4)) u_b (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .y_in(y_a), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .mismatch(mism_b), .first_err_idx(fidx_b), .first_err_got(fgot_b));

  fir_resp_checker #(.LATENCY(0)) u_c (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .y_in(y_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
    .mismatch(mism_c), .first_err_idx(fidx_c), .first_err_got(fgot_c));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [23:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    gold_m[a] = d;
  endtask

  // Reference: compare n sees gold_m[n mod 16]; the LATENCY=0 build may see a
  // pre-write value on compare 0 when a write coincides with start.
  task automatic predict(input bit for_c, output int errs, output int fidx, output logic [23:0] fgot);
    logic [23:0] s, g;
    errs = 0; fidx = 0; fgot = '0;
    for (int n = 0; n < 64; n++) begin
      s = for_c ? stim_c[n] : stim_a[n];
      g = gold_m[n % 16];
      if (for_c && n == 0 && ov_en) g = ov_val;
      if (s !== g) begin
        if (errs == 0) begin fidx = n % 16; fgot = s; end
        errs++;
      end
    end
  endtask

  task automatic do_run(input int inj_k, input int rst_k, input bit wr_start, input logic [23:0] wr_val);
    ba = 0; da = 0; ma = 0; bb = 0; db = 0; mb = 0; bc = 0; dc = 0; mc = 0;
    @(posedge clk); #1;
    start = 1'b1;
    if (wr_start) begin cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = wr_val; end
    for (int k = 0; k < 72; k++) begin
      @(posedge clk); #1;
      start = 1'b0; cfg_we = 1'b0;
      if (busy_a) ba++;
      if (done_a) da++;
      if (mism_a) ma++;
      if (busy_b) bb++;
      if (done_b) db++;
      if (mism_b) mb++;
      if (busy_c) bc++;
      if (done_c) dc++;
      if (mism_c) mc++;
      if (k == rst_k) begin
        reset_n = 1'b0; #1;
        chk("rst_mid.busy", 64'(busy_a), 64'd0);
        chk("rst_mid.err", 64'(err_a), 64'd0);
        chk("rst_mid.mism", 64'(mism_a), 64'd0);
        chk("rst_mid.fidx", 64'(fidx_a), 64'd0);
        chk("rst_mid.fgot", 64'(fgot_a), 64'd0);
        chk("rst_mid.busy_c", 64'(busy_c), 64'd0);
      end
      if (k == rst_k + 3) reset_n = 1'b1;
      if (k == inj_k) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 24'h123456;
      end
      y_a = (k >= 2 && k < 66) ? stim_a[k-2] : 24'h0;
      y_c = (k < 64) ? stim_c[k] : 24'h0;
    end
    start = 1'b0; cfg_we = 1'b0; reset_n = 1'b1;
  endtask

  task automatic check_results(input string tag);
    int ea, fa, ec, fc;
    logic [23:0] ga, gc;
    predict(1'b0, ea, fa, ga);
    predict(1'b1, ec, fc, gc);
    chk({tag, ".a_busy"}, 64'(ba), 64'd66);
    chk({tag, ".a_done"}, 64'(da), 64'd1);
    chk({tag, ".a_err"},  64'(err_a), 64'((ea > 65535) ? 65535 : ea));
    chk({tag, ".a_pass"}, 64'(pass_a), 64'(ea == 0));
    chk({tag, ".a_mism"}, 64'(ma), 64'(ea));
    chk({tag, ".a_fidx"}, 64'(fidx_a), 64'(fa));
    chk({tag, ".a_fgot"}, 64'(fgot_a), 64'(ga));
    chk({tag, ".b_busy"}, 64'(bb), 64'd66);
    chk({tag, ".b_done"}, 64'(db), 64'd1);
    chk({tag, ".b_err"},  64'(err_b), 64'((ea > 15) ? 15 : ea));
    chk({tag, ".b_pass"}, 64'(pass_b), 64'(ea == 0));
    chk({tag, ".b_mism"}, 64'(mb), 64'(ea));
    chk({tag, ".b_fidx"}, 64'(fidx_b), 64'(fa));
    chk({tag, ".b_fgot"}, 64'(fgot_b), 64'(ga));
    chk({tag, ".c_busy"}, 64'(bc), 64'd64);
    chk({tag, ".c_done"}, 64'(dc), 64'd1);
    chk({tag, ".c_err"},  64'(err_c), 64'(ec));
    chk({tag, ".c_pass"}, 64'(pass_c), 64'(ec == 0));
    chk({tag, ".c_mism"}, 64'(mc), 64'(ec));
    chk({tag, ".c_fidx"}, 64'(fidx_c), 64'(fc));
    chk({tag, ".c_fgot"}, 64'(fgot_c), 64'(gc));
  endtask

  task automatic clean_stim();
    for (int n = 0; n < 64; n++) begin
      stim_a[n] = gold_m[n % 16];
      stim_c[n] = gold_m[n % 16];
    end
  endtask

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; start = 1'b0;
    cfg_addr = '0; cfg_data = '0; y_a = '0; y_c = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 64'(busy_a), 64'd0);
    chk("reset.done", 64'(done_a), 64'd0);
    chk("reset.pass", 64'(pass_a), 64'd0);
    chk("reset.err",  64'(err_a), 64'd0);
    chk("reset.mism", 64'(mism_a), 64'd0);
    chk("reset.fidx", 64'(fidx_a), 64'd0);
    chk("reset.fgot", 64'(fgot_a), 64'd0);
    chk("reset.err_b", 64'(err_b), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) cfg_write(4'(i), 24'(i * 16));

    clean_stim();
    do_run(-1, -1, 1'b0, '0);
    check_results("clean");

    clean_stim();
    stim_a[16 + 5] = 24'h000055;
    stim_c[7]      = 24'h000777;
    do_run(-1, -1, 1'b0, '0);
    check_results("corrupt");

    clean_stim();
    for (int n = 0; n < 64; n++) stim_a[n] = 24'hFFFFFF;
    do_run(-1, -1, 1'b0, '0);
    check_results("saturate");

    clean_stim();
    do_run(10, -1, 1'b0, '0);
    check_results("busy_ignore");
    do_run(-1, -1, 1'b0, '0);
    check_results("gold3_kept");

    clean_stim();
    for (int n = 0; n < 10; n++) stim_a[n] = gold_m[n % 16] ^ 24'h000001;
    do_run(-1, 22, 1'b0, '0);
    chk("abort.done_a", 64'(da), 64'd0);
    chk("abort.done_c", 64'(dc), 64'd0);
    chk("abort.busy",   64'(busy_a), 64'd0);
    chk("abort.err",    64'(err_a), 64'd0);
    chk("abort.pass",   64'(pass_a), 64'd0);

    clean_stim();
    do_run(-1, -1, 1'b0, '0);
    check_results("after_abort");

    ov_en  = 1'b1;
    ov_val = gold_m[0];
    gold_m[0] = 24'hABCDEF;
    clean_stim();
    do_run(-1, -1, 1'b1, 24'hABCDEF);
    check_results("wr_with_start");
    ov_en = 1'b0;

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) cfg_write(4'(i), 24'($urandom));
      for (int n = 0; n < 64; n++) begin
        stim_a[n] = ($urandom_range(7) == 0) ? 24'($urandom) : gold_m[n % 16];
        stim_c[n] = ($urandom_range(7) == 0) ? 24'($urandom) : gold_m[n % 16];
      end
      do_run(-1, -1, 1'b0, '0);
      check_results($sformatf("random%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
